alu_issue: RTL and testbench

Execute-stage issue controller that sits directly upstream of the ALU top. It accepts decoded ALU operations from decode over a valid/ready handshake and registers operands and controls into the ALU. It sequences single-cycle and multi-cycle (mul/div) operations with a latency counter, fires the mul/div start pulse, and captures the ALU result. It then presents the result to writeback over a second valid/ready handshake. It also provides the stall/backpressure control that the ALU top itself does not implement.

---
 rtl/alu_issue_if.sv | 49 ++++
 rtl/alu_issue.sv | 166 ++++++++++++++++
 tb/tb_alu_issue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Purpose: groups the decode, ALU and writeback signals of the ALU issue controller.
// Latency: none; this is wiring only.
// Backpressure: carries the decode valid/ready pair and the writeback valid/ready pair.
interface alu_issue_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  // decode side
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_op_mode;
  logic [2:0]        i_func_op;
  logic              i_fp_mode;
  logic [XLEN-1:0]   i_a;
  logic [XLEN-1:0]   i_b;
  logic [REG_AW-1:0] i_rd;
  logic              i_flush;
  // ALU side
  logic [2:0]        o_alu_op_mode;
  logic [2:0]        o_alu_func_op;
  logic              o_alu_fp_mode;
  logic [XLEN-1:0]   o_alu_a;
  logic [XLEN-1:0]   o_alu_b;
  logic              o_alu_start;
  logic [XLEN-1:0]   i_alu_result;
  // writeback side and status
  logic              o_wb_valid;
  logic              i_wb_ready;
  logic [REG_AW-1:0] o_wb_rd;
  logic [XLEN-1:0]   o_wb_data;
  logic              o_illegal;
  logic              o_busy;

  // issue controller view
  modport slave (
    input  i_valid, i_op_mode, i_func_op, i_fp_mode, i_a, i_b, i_rd, i_flush,
    input  i_alu_result, i_wb_ready,
    output o_ready, o_alu_op_mode, o_alu_func_op, o_alu_fp_mode, o_alu_a, o_alu_b,
    output o_alu_start, o_wb_valid, o_wb_rd, o_wb_data, o_illegal, o_busy
  );

  // environment view (decode, ALU and writeback together)
  modport master (
    output i_valid, i_op_mode, i_func_op, i_fp_mode, i_a, i_b, i_rd, i_flush,
    output i_alu_result, i_wb_ready,
    input  o_ready, o_alu_op_mode, o_alu_func_op, o_alu_fp_mode, o_alu_a, o_alu_b,
    input  o_alu_start, o_wb_valid, o_wb_rd, o_wb_data, o_illegal, o_busy
  );
endinterface

// File: rtl/alu_issue.sv
// Purpose: issue controller in front of the ALU; registers ops, sequences mul/div latency, holds result for writeback.
// Latency: o_wb_valid rises 1 cycle after accept for modes 1-4, MUL_LAT for mul, DIV_LAT for div.
// Backpressure: o_ready only in IDLE or in DONE with i_wb_ready; the result is held in DONE while writeback stalls.
module alu_issue #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 34
) (
  input  logic      i_clk,
  input  logic      i_rst,
  alu_issue_if.slave bus
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, DRAIN} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              muldiv, muldiv_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        func_q, func_d;
  logic              fp_q, fp_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              start_q, start_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;

  logic ready;
  logic accept;
  logic legal;
  logic reject;
  logic [CW-1:0] lat_m1;

  // Ready is combinational so a DONE->EXEC handover costs no input bubble.
  assign ready  = !i_rst && !bus.i_flush &&
                  (state == IDLE || (state == DONE && bus.i_wb_ready));
  assign accept = bus.i_valid && ready;
  assign legal  = (bus.i_op_mode != 3'd0) && (bus.i_op_mode != 3'd7) && !bus.i_fp_mode;
  // Mode 0 is a silent no-op even if the FP bit happens to be set.
  assign reject = (bus.i_op_mode == 3'd7) || (bus.i_fp_mode && bus.i_op_mode != 3'd0);

  // Next-state and next-output computation for the issue FSM.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    muldiv_d   = muldiv;
    op_d       = op_q;
    func_d     = func_q;
    fp_d       = fp_q;
    a_d        = a_q;
    b_d        = b_q;
    start_d    = 1'b0;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;

    case (bus.i_op_mode)
      3'd5:    lat_m1 = CW'(MUL_LAT - 1);
      3'd6:    lat_m1 = CW'(DIV_LAT - 1);
      default: lat_m1 = '0;
    endcase

    case (state)
      EXEC: begin
        if (bus.i_flush) begin
          // A started mul/div must run to completion before the unit is reused.
          if (muldiv && cnt != '0) begin
            state_d = DRAIN;
            cnt_d   = cnt - CW'(1);
          end else begin
            state_d = IDLE;
          end
        end else if (cnt == '0) begin
          wb_valid_d = 1'b1;
          wb_data_d  = bus.i_alu_result;
          state_d    = DONE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      DONE: begin
        if (bus.i_flush || bus.i_wb_ready) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CW'(1);
      end
      default: ;
    endcase

    // A new op overrides whatever the DONE/IDLE handling decided.
    if (accept) begin
      if (legal) begin
        op_d     = bus.i_op_mode;
        func_d   = bus.i_func_op;
        fp_d     = bus.i_fp_mode;
        a_d      = bus.i_a;
        b_d      = bus.i_b;
        wb_rd_d  = bus.i_rd;
        cnt_d    = lat_m1;
        muldiv_d = (bus.i_op_mode == 3'd5) || (bus.i_op_mode == 3'd6);
        start_d  = (bus.i_op_mode == 3'd5) || (bus.i_op_mode == 3'd6);
        state_d  = EXEC;
      end else begin
        illegal_d = reject;
        state_d   = IDLE;
      end
    end
  end

  // State and output registers; reset wins over flush and every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      muldiv     <= 1'b0;
      op_q       <= '0;
      func_q     <= '0;
      fp_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      start_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      muldiv     <= muldiv_d;
      op_q       <= op_d;
      func_q     <= func_d;
      fp_q       <= fp_d;
      a_q        <= a_d;
      b_q        <= b_d;
      start_q    <= start_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_alu_op_mode = op_q;
  assign bus.o_alu_func_op = func_q;
  assign bus.o_alu_fp_mode = fp_q;
  assign bus.o_alu_a       = a_q;
  assign bus.o_alu_b       = b_q;
  assign bus.o_alu_start   = start_q;
  assign bus.o_wb_valid    = wb_valid_q;
  assign bus.o_wb_rd       = wb_rd_q;
  assign bus.o_wb_data     = wb_data_q;
  assign bus.o_illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Purpose: directed self-checking bench for alu_issue with a behavioural ALU.
// Latency: checks every output #1 after the rising edge that produced it.
// Backpressure: exercises writeback stalls, handover accepts and flush/drain.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] alu_res;

  alu_issue_if #(.XLEN(32), .REG_AW(5)) bus ();

  alu_issue #(.XLEN(32), .REG_AW(5), .MUL_LAT(4), .DIV_LAT(34)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: result is a function of the registered ALU inputs.
  always_comb begin
    alu_res = 32'd0;
    case (bus.o_alu_op_mode)
      3'd4:    alu_res = bus.o_alu_a + bus.o_alu_b;
      3'd5:    alu_res = bus.o_alu_a * bus.o_alu_b;
      3'd6:    alu_res = (bus.o_alu_b != 32'd0) ? bus.o_alu_a / bus.o_alu_b : 32'hFFFF_FFFF;
      default: alu_res = bus.o_alu_a;
    endcase
  end
  assign bus.i_alu_result = alu_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic fp,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.i_valid   = v;
    bus.i_op_mode = op;
    bus.i_func_op = 3'd0;
    bus.i_fp_mode = fp;
    bus.i_a       = a;
    bus.i_b       = b;
    bus.i_rd      = rd;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    bus.i_flush = 1'b0;
    bus.i_wb_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0d exp=0", bus.o_ready); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", bus.o_busy); end
    total++; if (bus.o_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0d exp=0", bus.o_wb_valid); end
    total++; if (bus.o_alu_op_mode !== 3'd0) begin bad++; $display("FAIL rst_op_mode got=%0d exp=0", bus.o_alu_op_mode); end
    total++; if (bus.o_alu_start !== 1'b0 || bus.o_illegal !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%0d%0d exp=00", bus.o_alu_start, bus.o_illegal); end
    rst = 1'b0;
    #1;
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0d exp=1", bus.o_ready); end
  endtask

  task automatic test_add();
    drive(1'b1, 3'd4, 1'b0, 32'd5, 32'd7, 5'd3);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    total++; if (bus.o_alu_a !== 32'd5 || bus.o_alu_b !== 32'd7) begin bad++; $display("FAIL add_operands got=%0d,%0d exp=5,7", bus.o_alu_a, bus.o_alu_b); end
    total++; if (bus.o_wb_valid !== 1'b0 || bus.o_busy !== 1'b1) begin bad++; $display("FAIL add_exec got=v%0d b%0d exp=v0 b1", bus.o_wb_valid, bus.o_busy); end
    total++; if (bus.o_alu_start !== 1'b0) begin bad++; $display("FAIL add_start got=%0d exp=0", bus.o_alu_start); end
    tick();
    total++; if (bus.o_wb_valid !== 1'b1) begin bad++; $display("FAIL add_wb_valid got=%0d exp=1", bus.o_wb_valid); end
    total++; if (bus.o_wb_data !== 32'd12 || bus.o_wb_rd !== 5'd3) begin bad++; $display("FAIL add_result got=%0d rd=%0d exp=12 rd=3", bus.o_wb_data, bus.o_wb_rd); end
    tick();
    total++; if (bus.o_wb_valid !== 1'b0 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL add_retire got=v%0d b%0d exp=v0 b0", bus.o_wb_valid, bus.o_busy); end
  endtask

  task automatic test_mul();
    int starts;
    drive(1'b1, 3'd5, 1'b0, 32'd6, 32'd7, 5'd9);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    starts = (bus.o_alu_start === 1'b1) ? 1 : 0;
    total++; if (bus.o_alu_start !== 1'b1) begin bad++; $display("FAIL mul_start_first got=%0d exp=1", bus.o_alu_start); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL mul_ready_c0 got=%0d exp=0", bus.o_ready); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (bus.o_alu_start === 1'b1) starts++;
      total++; if (bus.o_wb_valid !== 1'b0 || bus.o_ready !== 1'b0) begin bad++; $display("FAIL mul_exec_c%0d got=v%0d r%0d exp=v0 r0", i, bus.o_wb_valid, bus.o_ready); end
    end
    tick();
    total++; if (starts != 1) begin bad++; $display("FAIL mul_start_count got=%0d exp=1", starts); end
    total++; if (bus.o_wb_valid !== 1'b1 || bus.o_wb_data !== 32'd42) begin bad++; $display("FAIL mul_result got=v%0d d%0d exp=v1 d42", bus.o_wb_valid, bus.o_wb_data); end
    total++; if (bus.o_wb_rd !== 5'd9) begin bad++; $display("FAIL mul_rd got=%0d exp=9", bus.o_wb_rd); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.i_wb_ready = 1'b0;
    drive(1'b1, 3'd4, 1'b0, 32'd10, 32'd20, 5'd7);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.o_wb_valid !== 1'b1 || bus.o_wb_data !== 32'd30 || bus.o_wb_rd !== 5'd7) begin bad++; $display("FAIL bp_hold_c%0d got=v%0d d%0d rd%0d exp=v1 d30 rd7", i, bus.o_wb_valid, bus.o_wb_data, bus.o_wb_rd); end
      total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%0d exp=0", i, bus.o_ready); end
      if (i < 2) tick();
    end
    bus.i_wb_ready = 1'b1;
    drive(1'b1, 3'd4, 1'b0, 32'd1, 32'd1, 5'd2);
    #1;
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL bp_handover_ready got=%0d exp=1", bus.o_ready); end
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    total++; if (bus.o_wb_valid !== 1'b0 || bus.o_alu_a !== 32'd1) begin bad++; $display("FAIL bp_accept got=v%0d a%0d exp=v0 a1", bus.o_wb_valid, bus.o_alu_a); end
    tick();
    total++; if (bus.o_wb_valid !== 1'b1 || bus.o_wb_data !== 32'd2 || bus.o_wb_rd !== 5'd2) begin bad++; $display("FAIL bp_second got=v%0d d%0d rd%0d exp=v1 d2 rd2", bus.o_wb_valid, bus.o_wb_data, bus.o_wb_rd); end
    tick();
  endtask

  task automatic test_flush_div();
    int wb_seen;
    wb_seen = 0;
    drive(1'b1, 3'd6, 1'b0, 32'd100, 32'd5, 5'd4);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    for (int i = 1; i <= 33; i++) begin
      bus.i_flush = (i == 10);
      tick();
      bus.i_flush = 1'b0;
      #1;
      if (bus.o_wb_valid === 1'b1) wb_seen++;
      total++; if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0) begin bad++; $display("FAIL div_drain_c%0d got=b%0d r%0d exp=b1 r0", i, bus.o_busy, bus.o_ready); end
    end
    tick();
    if (bus.o_wb_valid === 1'b1) wb_seen++;
    total++; if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin bad++; $display("FAIL div_release got=b%0d r%0d exp=b0 r1", bus.o_busy, bus.o_ready); end
    tick();
    if (bus.o_wb_valid === 1'b1) wb_seen++;
    total++; if (wb_seen != 0) begin bad++; $display("FAIL div_no_wb got=%0d exp=0", wb_seen); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'd7, 1'b0, 32'd1, 32'd2, 5'd1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    total++; if (bus.o_illegal !== 1'b1) begin bad++; $display("FAIL ill_mode7 got=%0d exp=1", bus.o_illegal); end
    total++; if (bus.o_ready !== 1'b1 || bus.o_wb_valid !== 1'b0) begin bad++; $display("FAIL ill_mode7_state got=r%0d v%0d exp=r1 v0", bus.o_ready, bus.o_wb_valid); end
    tick();
    total++; if (bus.o_illegal !== 1'b0) begin bad++; $display("FAIL ill_mode7_width got=%0d exp=0", bus.o_illegal); end
    drive(1'b1, 3'd4, 1'b1, 32'd1, 32'd2, 5'd1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    total++; if (bus.o_illegal !== 1'b1 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL ill_fp got=i%0d b%0d exp=i1 b0", bus.o_illegal, bus.o_busy); end
    tick();
    total++; if (bus.o_illegal !== 1'b0 || bus.o_wb_valid !== 1'b0) begin bad++; $display("FAIL ill_fp_after got=i%0d v%0d exp=i0 v0", bus.o_illegal, bus.o_wb_valid); end
    drive(1'b1, 3'd0, 1'b0, 32'd1, 32'd2, 5'd1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    total++; if (bus.o_illegal !== 1'b0 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL nop_mode0 got=i%0d b%0d exp=i0 b0", bus.o_illegal, bus.o_busy); end
    tick();
    total++; if (bus.o_wb_valid !== 1'b0) begin bad++; $display("FAIL nop_no_wb got=%0d exp=0", bus.o_wb_valid); end
  endtask

  task automatic test_reset_mid();
    int wb_seen;
    wb_seen = 0;
    drive(1'b1, 3'd5, 1'b0, 32'd3, 32'd3, 5'd5);
    tick();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    total++; if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b0) begin bad++; $display("FAIL rmid_state got=b%0d r%0d exp=b0 r0", bus.o_busy, bus.o_ready); end
    total++; if (bus.o_alu_op_mode !== 3'd0 || bus.o_alu_a !== 32'd0 || bus.o_alu_b !== 32'd0) begin bad++; $display("FAIL rmid_alu got=m%0d a%0d b%0d exp=0", bus.o_alu_op_mode, bus.o_alu_a, bus.o_alu_b); end
    total++; if (bus.o_wb_data !== 32'd0 || bus.o_wb_rd !== 5'd0 || bus.o_wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_wb got=d%0d rd%0d v%0d exp=0", bus.o_wb_data, bus.o_wb_rd, bus.o_wb_valid); end
    total++; if (bus.o_alu_start !== 1'b0 || bus.o_illegal !== 1'b0) begin bad++; $display("FAIL rmid_pulses got=s%0d i%0d exp=0", bus.o_alu_start, bus.o_illegal); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.o_wb_valid === 1'b1 || bus.o_busy === 1'b1) wb_seen++;
    end
    total++; if (wb_seen != 0) begin bad++; $display("FAIL rmid_stale got=%0d exp=0", wb_seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_flush_div();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
